// File: rtl/ejercicio_3.sv
// 4-bit up/down counter with enable, shown on a common-anode active-low seven-segment display.
// Hex mode: SEG/AN combinational from the count. EJ3_DECIMAL_DISPLAY_EN: two scanned digits, registered, 1 cycle behind.
// No backpressure: the counter steps on every enabled clock and the display simply follows it.
module ejercicio_3 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hab,
    input  logic       dir,
    output logic [3:0] cnt,
    output logic [6:0] SEG,
    output logic [3:0] AN
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    if (REFRESH_DIV < 2) begin : g_div_check
        $error("REFRESH_DIV must be at least 2");
    end

    // Segment pattern for one hex digit, bit order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hab) begin
            cnt_d = dir ? cnt_q + 4'd1 : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

`ifdef EJ3_DECIMAL_DISPLAY_EN
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    units;

    // sel_q = 0 drives the units digit, 1 drives the tens digit.
    always_comb begin
        presc_d = presc_q + PW'(1);
        sel_d   = sel_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            sel_d   = ~sel_q;
        end

        units = (cnt_q >= 4'd10) ? cnt_q - 4'd10 : cnt_q;

        an_d  = 4'b1110;
        seg_d = glyph(units);
        if (sel_q) begin
            an_d  = 4'b1101;
            seg_d = (cnt_q >= 4'd10) ? glyph(4'd1) : SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= 1'b0;
            seg_q   <= 7'b1000000;
            an_q    <= 4'b1110;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
`else
    assign SEG = glyph(cnt_q);
    assign AN  = 4'b1110;
`endif

endmodule

// File: tb/tb_ejercicio_3.sv
// Bench for ejercicio_3: directed walk through counting, wrap, hold and reset, then random traffic,
// every cycle compared against a arithmetic reference model of count and display.
module tb_ejercicio_3;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hab = 1'b0;
    logic       dir = 1'b1;
    logic [3:0] cnt;
    logic [6:0] SEG;
    logic [3:0] AN;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] glyph_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    // Reference state
    int         m_cnt = 0;
    int         m_edges = 0;
    logic [6:0] m_seg = 7'b1000000;
    logic [3:0] m_an = 4'b1110;

    ejercicio_3 #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .hab (hab),
        .dir (dir),
        .cnt (cnt),
        .SEG (SEG),
        .AN  (AN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance model on the edge, compare at the falling edge.
    task automatic cycle(input logic r, input logic h, input logic d);
        int sel;
        rst = r;
        hab = h;
        dir = d;
        @(posedge clk);
`ifdef EJ3_DECIMAL_DISPLAY_EN
        if (r) begin
            m_edges = 0;
            m_seg   = glyph_tbl[0];
            m_an    = 4'b1110;
        end else begin
            sel = (m_edges / DIV) % 2;
            if (sel == 1) begin
                m_an  = 4'b1101;
                m_seg = (m_cnt >= 10) ? glyph_tbl[1] : BLANK;
            end else begin
                m_an  = 4'b1110;
                m_seg = glyph_tbl[m_cnt % 10];
            end
            m_edges++;
        end
`endif
        if (r)      m_cnt = 0;
        else if (h) m_cnt = d ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
`ifndef EJ3_DECIMAL_DISPLAY_EN
        m_seg = glyph_tbl[m_cnt];
        m_an  = 4'b1110;
`endif
        @(negedge clk);
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("seg", 32'(SEG), 32'(m_seg));
        chk("an",  32'(AN),  32'(m_an));
    endtask

    task automatic run(input int n, input logic h, input logic d);
        for (int i = 0; i < n; i++) cycle(1'b0, h, d);
    endtask

    initial begin
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_seg", 32'(SEG), 32'h40);
        chk("reset_an",  32'(AN),  32'he);

        run(10, 1'b1, 1'b1);
        chk("up10_cnt", 32'(cnt), 32'd10);
`ifndef EJ3_DECIMAL_DISPLAY_EN
        chk("up10_seg_A", 32'(SEG), 32'h08);
`endif
        run(5, 1'b1, 1'b1);
        chk("up15_cnt", 32'(cnt), 32'd15);
        run(1, 1'b1, 1'b1);
        chk("wrap_up_cnt", 32'(cnt), 32'd0);

        run(10, 1'b1, 1'b1);
        run(10, 1'b1, 1'b0);
        chk("down10_cnt", 32'(cnt), 32'd0);
        run(1, 1'b1, 1'b0);
        chk("wrap_down_cnt", 32'(cnt), 32'd15);
`ifndef EJ3_DECIMAL_DISPLAY_EN
        chk("wrap_down_seg_F", 32'(SEG), 32'h0e);
`endif

        run(8, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        chk("hold_cnt", 32'(cnt), 32'd7);
`ifndef EJ3_DECIMAL_DISPLAY_EN
        chk("hold_seg_7", 32'(SEG), 32'h78);
`endif
        run(8, 1'b1, 1'b1);
        chk("after_hold_cnt", 32'(cnt), 32'd15);

        run(10, 1'b1, 1'b1);
        chk("pre_rst_cnt", 32'(cnt), 32'd9);
        cycle(1'b1, 1'b1, 1'b1);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        run(1, 1'b1, 1'b1);
        chk("post_rst_cnt", 32'(cnt), 32'd1);

        // Park on 12, then on 5, long enough to watch several scan periods.
        run(11, 1'b1, 1'b1);
        run(4 * DIV, 1'b0, 1'b1);
        run(7, 1'b1, 1'b0);
        chk("park5_cnt", 32'(cnt), 32'd5);
        run(4 * DIV, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
